// File: rtl/sd_wb_dma.sv
// sd_wb_dma: Wishbone B3 classic master for the SD sector manager's external
// block handshakes. A read request fetches one 128-word sector from system
// memory into the read-buffer BRAM. A write request streams one sector from
// the write-buffer BRAM out to system memory. Bus errors and per-beat timeouts
// are flagged but never retried, so a sector always completes its 128 beats.
module sd_wb_dma #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          WB_TIMEOUT = 1023
) (
  input  logic        clk_50,
  input  logic        reset_n,
  input  logic        ext_read_act,
  output logic        ext_read_go,
  input  logic [31:0] ext_read_addr,
  input  logic        ext_read_stop,
  input  logic        ext_write_act,
  output logic        ext_write_done,
  input  logic [31:0] ext_write_addr,
  output logic [6:0]  bram_rd_ext_addr,
  output logic        bram_rd_ext_wren,
  output logic [31:0] bram_rd_ext_data,
  output logic [6:0]  bram_wr_ext_addr,
  input  logic [31:0] bram_wr_ext_q,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic        err_flag
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD_BEAT  = 3'd1;
  localparam logic [2:0] S_RD_GO    = 3'd2;
  localparam logic [2:0] S_RD_WAIT  = 3'd3;
  localparam logic [2:0] S_WR_FETCH = 3'd4;
  localparam logic [2:0] S_WR_BEAT  = 3'd5;
  localparam logic [2:0] S_WR_DONE  = 3'd6;

  // A beat is abandoned on the cycle its strobe has been high WB_TIMEOUT cycles.
  localparam logic [9:0] TMO_LAST = 10'(WB_TIMEOUT - 1);

  logic [2:0]  r_state;
  logic [6:0]  r_word;
  logic [22:0] r_sector;
  logic [9:0]  r_tmo;
  logic        r_cyc;
  logic        r_stb;
  logic        r_we;
  logic [31:0] r_dat_o;
  logic        r_rd_wren;
  logic [6:0]  r_rd_addr;
  logic [31:0] r_rd_data;
  logic        r_go;
  logic        r_done;
  logic        r_err;

  logic        w_tmo_hit;
  logic        w_beat_end;
  logic        w_beat_bad;
  logic [31:0] w_adr;
  logic        w_unused_addr_bits;

  // Sector numbers above bit 22 would address past 4 GiB and are dropped.
  assign w_unused_addr_bits = ^{ext_read_addr[31:23], ext_write_addr[31:23]};

  assign w_tmo_hit  = (r_tmo == TMO_LAST);
  assign w_beat_end = r_stb & (wb_ack_i | wb_err_i | w_tmo_hit);
  // An ack arriving on the last allowed cycle still counts as a good beat.
  assign w_beat_bad = wb_err_i | (~wb_ack_i & w_tmo_hit);
  // Sector and word offsets are added to the base with natural 32-bit wrap.
  assign w_adr      = BASE_ADDR + {r_sector, 9'd0} + {23'd0, r_word, 2'b00};

  assign wb_adr_o         = r_cyc ? w_adr : 32'd0;
  assign wb_dat_o         = r_dat_o;
  assign wb_sel_o         = 4'hF;
  assign wb_we_o          = r_we;
  assign wb_cyc_o         = r_cyc;
  assign wb_stb_o         = r_stb;
  assign ext_read_go      = r_go;
  assign ext_write_done   = r_done;
  assign bram_rd_ext_addr = r_rd_addr;
  assign bram_rd_ext_wren = r_rd_wren;
  assign bram_rd_ext_data = r_rd_data;
  assign bram_wr_ext_addr = r_word;
  assign err_flag         = r_err;

  // Per-beat timeout counter: runs while strobe waits, saturates, clears per beat.
  always_ff @(posedge clk_50) begin
    // NOTE: all state updates use non-blocking assignment so every register
    // samples the pre-edge values, independent of statement order.
    if (!reset_n) begin
      r_tmo <= 10'd0;
    end else if (!r_stb || w_beat_end) begin
      r_tmo <= 10'd0;
    end else if (r_tmo != 10'h3FF) begin
      r_tmo <= r_tmo + 10'd1;
    end
  end

  // Transfer sequencer: request arbitration, bus beats, BRAM moves, handshakes.
  always_ff @(posedge clk_50) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_word    <= 7'd0;
      r_sector  <= 23'd0;
      r_cyc     <= 1'b0;
      r_stb     <= 1'b0;
      r_we      <= 1'b0;
      r_dat_o   <= 32'd0;
      r_rd_wren <= 1'b0;
      r_rd_addr <= 7'd0;
      r_rd_data <= 32'd0;
      r_go      <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      // NOTE: the BRAM write strobe defaults low here so it is a one-cycle
      // pulse unless a beat completes on this edge.
      r_rd_wren <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ext_read_act) begin
            r_state  <= S_RD_BEAT;
            r_sector <= ext_read_addr[22:0];
            r_word   <= 7'd0;
            r_err    <= 1'b0;
            r_cyc    <= 1'b1;
            r_stb    <= 1'b1;
            r_we     <= 1'b0;
          end else if (ext_write_act) begin
            r_state  <= S_WR_FETCH;
            r_sector <= ext_write_addr[22:0];
            r_word   <= 7'd0;
            r_err    <= 1'b0;
          end
        end
        S_RD_BEAT: begin
          if (!r_stb) begin
            r_stb <= 1'b1;
          end else if (w_beat_end) begin
            r_rd_wren <= 1'b1;
            r_rd_addr <= r_word;
            r_rd_data <= w_beat_bad ? 32'd0 : wb_dat_i;
            r_stb     <= 1'b0;
            r_word    <= r_word + 7'd1;
            if (w_beat_bad) r_err <= 1'b1;
            if (r_word == 7'd127) begin
              r_cyc   <= 1'b0;
              r_state <= S_RD_GO;
            end
          end
        end
        S_RD_GO: begin
          // go rises one cycle after the last BRAM write has landed.
          if (r_go && ext_read_stop) begin
            r_go    <= 1'b0;
            r_state <= S_RD_WAIT;
          end else begin
            r_go <= 1'b1;
          end
        end
        S_RD_WAIT: begin
          if (!ext_read_stop && !ext_read_act) r_state <= S_IDLE;
        end
        S_WR_FETCH: begin
          // The word address has been on the BRAM since the previous edge.
          r_state <= S_WR_BEAT;
        end
        S_WR_BEAT: begin
          if (!r_stb) begin
            r_dat_o <= bram_wr_ext_q;
            r_cyc   <= 1'b1;
            r_stb   <= 1'b1;
            r_we    <= 1'b1;
          end else if (w_beat_end) begin
            r_stb  <= 1'b0;
            r_word <= r_word + 7'd1;
            if (w_beat_bad) r_err <= 1'b1;
            if (r_word == 7'd127) begin
              r_cyc   <= 1'b0;
              r_we    <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_WR_DONE;
            end else begin
              r_state <= S_WR_FETCH;
            end
          end
        end
        S_WR_DONE: begin
          if (!ext_write_act) begin
            r_done  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_wb_dma.sv
// Testbench for sd_wb_dma: Wishbone slave with memory, wait states, error and
// no-ack injection, BRAM models, and a sector-level reference computed from
// base + sector*512 + word*4 address arithmetic.
module tb_sd_wb_dma;

  localparam logic [31:0] BASE_A = 32'h1000_0000;
  localparam logic [31:0] BASE_B = 32'hFFFF_FE00;
  localparam int          BOUND  = 20000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        rd_act, rd_stop, wr_act;
  logic [31:0] rd_addr, wr_addr;
  logic        rd_go, wr_done, brd_wren;
  logic [6:0]  brd_addr, bwr_addr;
  logic [31:0] brd_data, bwr_q;
  logic [31:0] adr, dat_o, dat_i;
  logic [3:0]  sel;
  logic        we, cyc, stb, ack, err, err_flag;

  logic        b_act, b_stop, b_go, b_we, b_cyc, b_stb;
  logic [31:0] b_adr, b_dat_o;
  logic        unused_b_done, unused_b_wren, unused_b_err;
  logic [6:0]  unused_b_rd_addr, unused_b_wr_addr;
  logic [31:0] unused_b_rd_data;
  logic [3:0]  unused_b_sel;

  sd_wb_dma #(.BASE_ADDR(BASE_A)) dut (
    .clk_50(clk), .reset_n(reset_n),
    .ext_read_act(rd_act), .ext_read_go(rd_go), .ext_read_addr(rd_addr), .ext_read_stop(rd_stop),
    .ext_write_act(wr_act), .ext_write_done(wr_done), .ext_write_addr(wr_addr),
    .bram_rd_ext_addr(brd_addr), .bram_rd_ext_wren(brd_wren), .bram_rd_ext_data(brd_data),
    .bram_wr_ext_addr(bwr_addr), .bram_wr_ext_q(bwr_q),
    .wb_adr_o(adr), .wb_dat_o(dat_o), .wb_dat_i(dat_i), .wb_sel_o(sel), .wb_we_o(we),
    .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_ack_i(ack), .wb_err_i(err), .err_flag(err_flag)
  );

  sd_wb_dma #(.BASE_ADDR(BASE_B)) dut_b (
    .clk_50(clk), .reset_n(reset_n),
    .ext_read_act(b_act), .ext_read_go(b_go), .ext_read_addr(32'h007F_FFFF), .ext_read_stop(b_stop),
    .ext_write_act(1'b0), .ext_write_done(unused_b_done), .ext_write_addr(32'd0),
    .bram_rd_ext_addr(unused_b_rd_addr), .bram_rd_ext_wren(unused_b_wren), .bram_rd_ext_data(unused_b_rd_data),
    .bram_wr_ext_addr(unused_b_wr_addr), .bram_wr_ext_q(32'd0),
    .wb_adr_o(b_adr), .wb_dat_o(b_dat_o), .wb_dat_i(~b_adr), .wb_sel_o(unused_b_sel), .wb_we_o(b_we),
    .wb_cyc_o(b_cyc), .wb_stb_o(b_stb), .wb_ack_i(b_stb), .wb_err_i(1'b0), .err_flag(unused_b_err)
  );

  int n_vec = 0;
  int n_mis = 0;

  // ---------------- slave memory model ----------------
  int          n_wait = 0, err_beat = -1, noack_beat = -1, wcnt = 0;
  logic [31:0] seed = 32'd0;
  logic        resp;

  function automatic logic [31:0] mdat(input logic [31:0] a, input logic [31:0] s);
    return (a * 32'h9E37_79B1) ^ s;
  endfunction

  function automatic logic [31:0] exp_adr(input logic [31:0] base, input logic [31:0] sec, input int k);
    logic [63:0] full;
    full = 64'(base) + 64'(sec % 32'h0080_0000) * 64'd512 + 64'(k) * 64'd4;
    return full[31:0];
  endfunction

  assign resp  = cyc && stb && (wcnt >= n_wait);
  assign err   = resp && (int'(adr[8:2]) == err_beat);
  assign ack   = resp && (int'(adr[8:2]) != err_beat) && (int'(adr[8:2]) != noack_beat);
  assign dat_i = mdat(adr, seed);
  always @(posedge clk) wcnt <= (stb && !ack && !err) ? wcnt + 1 : 0;

  logic [31:0] wr_bram [128];
  always @(posedge clk) bwr_q <= wr_bram[bwr_addr];

  // ---------------- loggers (sampled on the falling edge) ----------------
  logic [31:0] lg_adr[$], lg_dat[$], b_lg_adr[$];
  logic        lg_we[$];
  logic [3:0]  lg_sel[$];
  logic [31:0] rd_bram [128];
  int          rd_wr_cnt = 0, stab_bad = 0, noack_cyc = 0;
  logic        p_stb = 1'b0, b_p_stb = 1'b0;
  logic [31:0] p_adr = 32'd0, p_dat = 32'd0;

  always @(negedge clk) begin
    if (stb && !p_stb) begin
      lg_adr.push_back(adr); lg_dat.push_back(dat_o); lg_we.push_back(we); lg_sel.push_back(sel);
    end else if (stb && (adr !== p_adr || dat_o !== p_dat)) begin
      stab_bad++;
    end
    if (stb && noack_beat >= 0 && int'(adr[8:2]) == noack_beat) noack_cyc++;
    if (brd_wren) begin rd_bram[brd_addr] = brd_data; rd_wr_cnt++; end
    p_stb = stb; p_adr = adr; p_dat = dat_o;
    if (b_stb && !b_p_stb) b_lg_adr.push_back(b_adr);
    b_p_stb = b_stb;
  end

  // ---------------- helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clr;
    lg_adr.delete(); lg_dat.delete(); lg_we.delete(); lg_sel.delete(); b_lg_adr.delete();
    rd_wr_cnt = 0; stab_bad = 0; noack_cyc = 0;
    for (int k = 0; k < 128; k++) rd_bram[k] = 32'hDEAD_BEEF;
  endtask

  // which: 0 = read go, 1 = write done, 2 = second instance read go
  task automatic wait_for(input int which, output int cnt);
    logic s;
    cnt = 0; s = 1'b0;
    while (!s && cnt < BOUND) begin
      tick(1); cnt++;
      s = (which == 0) ? rd_go : (which == 1) ? wr_done : b_go;
    end
    check("wait_bound", 32'(s), 32'd1);
  endtask

  task automatic chk_read(input logic [31:0] sec);
    logic [31:0] ea;
    check("rd_beats", 32'(lg_adr.size()), 32'd128);
    check("rd_bram_writes", 32'(rd_wr_cnt), 32'd128);
    for (int k = 0; k < 128; k++) begin
      ea = exp_adr(BASE_A, sec, k);
      if (k < lg_adr.size()) begin
        check($sformatf("rd_adr[%0d]", k), lg_adr[k], ea);
        check($sformatf("rd_we[%0d]", k), 32'(lg_we[k]), 32'd0);
        check($sformatf("rd_sel[%0d]", k), 32'(lg_sel[k]), 32'hF);
      end
      check($sformatf("rd_bram[%0d]", k), rd_bram[k],
            (k == err_beat || k == noack_beat) ? 32'd0 : mdat(ea, seed));
    end
  endtask

  task automatic chk_write(input logic [31:0] sec);
    check("wr_beats", 32'(lg_adr.size()), 32'd128);
    check("wr_stable", 32'(stab_bad), 32'd0);
    for (int k = 0; k < 128 && k < lg_adr.size(); k++) begin
      check($sformatf("wr_adr[%0d]", k), lg_adr[k], exp_adr(BASE_A, sec, k));
      check($sformatf("wr_dat[%0d]", k), lg_dat[k], wr_bram[k]);
      check($sformatf("wr_we[%0d]", k), 32'(lg_we[k]), 32'd1);
      check($sformatf("wr_sel[%0d]", k), 32'(lg_sel[k]), 32'hF);
    end
  endtask

  task automatic rd_finish;
    tick(2);
    check("go_held", 32'(rd_go), 32'd1);
    rd_stop = 1'b1; tick(1);
    check("go_drop", 32'(rd_go), 32'd0);
    rd_stop = 1'b0; rd_act = 1'b0; tick(2);
  endtask

  task automatic wr_finish;
    tick(2);
    check("done_held", 32'(wr_done), 32'd1);
    wr_act = 1'b0; tick(1);
    check("done_drop", 32'(wr_done), 32'd0);
    tick(1);
  endtask

  // ---------------- directed + randomized sequence ----------------
  initial begin
    int          cnt;
    logic [31:0] sec, wsec;
    reset_n = 1'b0; rd_act = 1'b0; rd_stop = 1'b0; wr_act = 1'b0; b_act = 1'b0; b_stop = 1'b0;
    rd_addr = 32'd0; wr_addr = 32'd0; seed = $urandom;
    for (int k = 0; k < 128; k++) wr_bram[k] = $urandom;
    clr();
    tick(3);

    // Reset state: every output low.
    check("rst_go", 32'(rd_go), 32'd0);
    check("rst_done", 32'(wr_done), 32'd0);
    check("rst_cyc", 32'(cyc), 32'd0);
    check("rst_stb", 32'(stb), 32'd0);
    check("rst_we", 32'(we), 32'd0);
    check("rst_adr", adr, 32'd0);
    check("rst_dat", dat_o, 32'd0);
    check("rst_wren", 32'(brd_wren), 32'd0);
    check("rst_rd_addr", 32'(brd_addr), 32'd0);
    check("rst_rd_data", brd_data, 32'd0);
    check("rst_wr_addr", 32'(bwr_addr), 32'd0);
    check("rst_err", 32'(err_flag), 32'd0);
    reset_n = 1'b1; tick(2);

    // Zero-wait read of sector 3: go appears 256 edges after the sampling edge.
    clr(); n_wait = 0; rd_addr = 32'd3; rd_act = 1'b1;
    wait_for(0, cnt);
    check("rd_latency", 32'(cnt), 32'd257);
    check("rd_err", 32'(err_flag), 32'd0);
    chk_read(32'd3);
    rd_finish();

    // Write of sector 0 with two wait states per beat.
    clr(); n_wait = 2;
    for (int k = 0; k < 128; k++) wr_bram[k] = 32'hA500_0000 + 32'(k);
    wr_addr = 32'd0; wr_act = 1'b1;
    tick(1);
    check("wr_done_low_start", 32'(wr_done), 32'd0);
    wait_for(1, cnt);
    chk_write(32'd0);
    wr_finish();

    // Simultaneous requests: the read is serviced and handshaken first.
    clr(); n_wait = $urandom_range(0, 1);
    sec = $urandom; wsec = $urandom;
    for (int k = 0; k < 128; k++) wr_bram[k] = $urandom;
    rd_addr = sec; wr_addr = wsec; rd_act = 1'b1; wr_act = 1'b1;
    wait_for(0, cnt);
    check("both_done_low", 32'(wr_done), 32'd0);
    chk_read(sec);
    clr();
    rd_finish();
    check("both_wr_not_started", 32'(lg_adr.size()), 32'd0);
    wait_for(1, cnt);
    chk_write(wsec);
    wr_finish();

    // Bus error on beat 5 and a missing ack on beat 9 of a read.
    clr(); n_wait = 0; err_beat = 5; noack_beat = 9; sec = $urandom;
    rd_addr = sec; rd_act = 1'b1;
    wait_for(0, cnt);
    check("err_flag_set", 32'(err_flag), 32'd1);
    check("timeout_cycles", 32'(noack_cyc), 32'd1023);
    chk_read(sec);
    rd_finish();
    check("err_flag_sticky", 32'(err_flag), 32'd1);
    err_beat = -1; noack_beat = -1;
    clr(); wsec = $urandom; wr_addr = wsec; wr_act = 1'b1;
    tick(1);
    check("err_flag_cleared", 32'(err_flag), 32'd0);
    wait_for(1, cnt);
    chk_write(wsec);
    wr_finish();

    // Address wrap on the second instance.
    clr(); b_act = 1'b1;
    wait_for(2, cnt);
    check("b_latency", 32'(cnt), 32'd257);
    check("b_beats", 32'(b_lg_adr.size()), 32'd128);
    for (int k = 0; k < 128 && k < b_lg_adr.size(); k++)
      check($sformatf("b_adr[%0d]", k), b_lg_adr[k], exp_adr(BASE_B, 32'h007F_FFFF, k));
    b_stop = 1'b1; tick(1);
    check("b_go_drop", 32'(b_go), 32'd0);
    b_stop = 1'b0; b_act = 1'b0; tick(2);

    // Reset during beat 40 of a write, then a clean read.
    clr(); n_wait = $urandom_range(0, 2); wr_addr = $urandom; wr_act = 1'b1;
    cnt = 0;
    while (lg_adr.size() < 41 && cnt < BOUND) begin tick(1); cnt++; end
    check("beat40_reached", 32'(lg_adr.size()), 32'd41);
    reset_n = 1'b0; wr_act = 1'b0; tick(1);
    check("mid_rst_cyc", 32'(cyc), 32'd0);
    check("mid_rst_stb", 32'(stb), 32'd0);
    check("mid_rst_we", 32'(we), 32'd0);
    check("mid_rst_done", 32'(wr_done), 32'd0);
    check("mid_rst_adr", adr, 32'd0);
    reset_n = 1'b1; tick(2);
    check("post_rst_idle", 32'(cyc), 32'd0);
    clr(); n_wait = 0; sec = $urandom; rd_addr = sec; rd_act = 1'b1;
    wait_for(0, cnt);
    check("post_rst_latency", 32'(cnt), 32'd257);
    chk_read(sec);
    rd_finish();

    // Randomized transfers with random wait states and contents.
    for (int t = 0; t < 4; t++) begin
      clr(); n_wait = $urandom_range(0, 3); sec = $urandom; seed = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        rd_addr = sec; rd_act = 1'b1;
        wait_for(0, cnt);
        chk_read(sec);
        rd_finish();
      end else begin
        for (int k = 0; k < 128; k++) wr_bram[k] = $urandom;
        wr_addr = sec; wr_act = 1'b1;
        wait_for(1, cnt);
        chk_write(sec);
        wr_finish();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
